broadcast_ctrl: RTL
===================

# broadcast_ctrl

Sequencer for the broadcast unit. On a start command it clears the broadcast cache, then streams `ceil(num_elems/8)` 8-byte beats from SRAM into the cache. It then issues a requested number of broadcast-enable cycles, throttled by downstream ready, and reports completion or parameter errors. It sits between the top-level layer controller, the weight/data SRAM read port and one broadcast unit instance.

## Interface
Parameters:
- `ADDR_W`, 16: SRAM word-address width and cache byte-address width.
- `CACHE_DEPTH`, 512: broadcast cache entries (bytes); upper limit for `num_elems_i`.
- `LANES`, 8: bytes per beat and per broadcast vector.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-low.
- `start_i` in 1: command strobe; accepted only in IDLE.
- `src_base_i` in ADDR_W: SRAM word address of the first beat.
- `num_elems_i` in 32: element count to load and wrap over.
- `num_vectors_i` in 32: number of broadcast vectors to emit.
- `out_ready_i` in 1: downstream can accept a vector this cycle.
- `sram_rd_en_o` out 1: SRAM read request.
- `sram_addr_o` out ADDR_W: SRAM word address.
- `sram_rdata_i` in 8*LANES: read data.
- `sram_rvalid_i` in 1: read data valid; in order, any fixed latency ≥1.
- `bu_init_o` out 1: broadcast-unit init pulse.
- `bu_valid_o` out 1: cache write strobe.
- `bu_addr_o` out ADDR_W: cache byte address.
- `bu_data_o` out 8*LANES: cache write data.
- `bu_en_o` out 1: broadcast enable.
- `bu_num_elems_o` out 32: latched element count.
- `busy_o` out 1: not IDLE.
- `done_o` out 1: one-cycle completion pulse.
- `err_o` out 1: one-cycle rejected-command pulse.

## Operation
- States: IDLE, INIT, LOAD, DRAIN, BCAST, DONE.
- IDLE:
  - On `start_i`, latch `src_base_i`, `num_elems_i` and `num_vectors_i`.
  - If `num_elems==0` or `num_elems>CACHE_DEPTH`: pulse `err_o` next cycle and stay in IDLE.
  - Otherwise go to INIT.
- INIT:
  - `bu_init_o=1` for exactly one cycle.
  - Clear counters: `beats = (num_elems+LANES-1)/LANES`, `rd_cnt=0`, `rx_cnt=0`, `vec_cnt=0`.
  - Go to LOAD.
- LOAD:
  - `sram_rd_en_o=1` every cycle, with `sram_addr_o = base + rd_cnt` (ADDR_W wrap).
  - `rd_cnt++` per cycle.
  - After the read with `rd_cnt==beats-1`, go to DRAIN.
- Write path (LOAD and DRAIN):
  - Each `sram_rvalid_i` produces, registered one cycle later: `bu_valid_o=1`, `bu_addr_o = rx_cnt*LANES`, `bu_data_o = sram_rdata_i`.
  - `rx_cnt++` on each `sram_rvalid_i`.
  - `sram_rvalid_i` is ignored in IDLE, INIT, BCAST and DONE.
- DRAIN:
  - Wait until `rx_cnt==beats` and the last cache write has been issued.
  - Then go to BCAST, or directly to DONE if `num_vectors==0`.
- BCAST:
  - `bu_en_o = out_ready_i` (combinational).
  - `vec_cnt++` on each enabled cycle.
  - On the enable with `vec_cnt==num_vectors-1`, go to DONE.
- DONE:
  - `done_o=1` for one cycle, aligned with the broadcast unit's `valid_o` for the last vector.
  - Go to IDLE.
- `bu_num_elems_o` holds the latched value from acceptance until the next accepted start.
- `start_i` outside IDLE is ignored, with no error.
- Counters are 32 bits; `beats ≤ CACHE_DEPTH/LANES`.

## Timing
- Reset values: all outputs 0; state IDLE; latched registers 0.
- Reset mid-operation returns to IDLE the next cycle. SRAM data still in flight is discarded.
- Start at cycle 0:
  - `bu_init_o` at cycle 1.
  - First `sram_rd_en_o` at cycle 2.
  - Last read at cycle `1+beats`.
- With SRAM latency L, the last cache write appears at cycle `2+beats+L`. The first possible `bu_en_o` is at cycle `3+beats+L`.
- Cache writes never overlap `bu_en_o`.
- Throughput: one beat per cycle in LOAD, one vector per cycle when `out_ready_i=1`.
- `out_ready_i` low stalls BCAST indefinitely with no state change.

## Structure
- Shared package `npu_ctrl_pkg`:
  - State enum `bcast_state_t`.
  - Constants `BCAST_LANES=8`, `BCAST_CACHE_DEPTH=512`.
  - Reused by other sequencers.
- Single module with no sub-module. The three counters and the FSM are flat.
- A top-level wrapper instantiates this block together with the broadcast unit.

## Test plan
- `num_elems=3`, `num_vectors=4`, L=1, ready always high:
  - 1 read at base.
  - Broadcast unit outputs wrap 0,1,2,0,1,2,0,1 …
  - `done_o` at cycle 9.
- `num_elems=20`, base=0x40, L=2:
  - 3 reads at 0x40–0x42.
  - Cache writes at 0, 8, 16.
  - `bu_en_o` first at cycle 8.
- `num_elems=0`, then `num_elems=513` → `err_o` pulses, `busy_o` stays 0, no SRAM reads.
- `num_vectors=5`, `out_ready_i` toggling 1010…:
  - Exactly 5 `bu_en_o` cycles, each coincident with ready.
  - `done_o` the cycle after the 5th.
- `num_vectors=0` → load completes, no `bu_en_o`, `done_o` follows DRAIN.
- `rst` low during LOAD with reads outstanding:
  - Next cycle all outputs are 0.
  - Late `sram_rvalid_i` produces no `bu_valid_o`.
  - A new start works normally.

Source files
------------

// File: rtl/npu_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | npu_ctrl_pkg                                                             |
// | Shared types and constants for the NPU layer sequencers.                 |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package npu_ctrl_pkg;

  localparam int BCAST_LANES       = 8;
  localparam int BCAST_CACHE_DEPTH = 512;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_LOAD  = 3'd2,
    S_DRAIN = 3'd3,
    S_BCAST = 3'd4,
    S_DONE  = 3'd5
  } bcast_state_t;

  // Number of whole beats needed to cover n bytes at 'lanes' bytes per beat.
  function automatic logic [31:0] beats_for(input logic [31:0] n, input int lanes);
    return (n + 32'(lanes) - 32'd1) / 32'(lanes);
  endfunction

endpackage
`default_nettype wire

// File: rtl/broadcast_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | broadcast_ctrl                                                           |
// | Loads the broadcast cache from SRAM, then paces broadcast-enable cycles. |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module broadcast_ctrl
  import npu_ctrl_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int CACHE_DEPTH = BCAST_CACHE_DEPTH,
  parameter int LANES       = BCAST_LANES
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic [ADDR_W-1:0]    src_base_i,
  input  logic [31:0]          num_elems_i,
  input  logic [31:0]          num_vectors_i,
  input  logic                 out_ready_i,
  output logic                 sram_rd_en_o,
  output logic [ADDR_W-1:0]    sram_addr_o,
  input  logic [8*LANES-1:0]   sram_rdata_i,
  input  logic                 sram_rvalid_i,
  output logic                 bu_init_o,
  output logic                 bu_valid_o,
  output logic [ADDR_W-1:0]    bu_addr_o,
  output logic [8*LANES-1:0]   bu_data_o,
  output logic                 bu_en_o,
  output logic [31:0]          bu_num_elems_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o
);

  bcast_state_t          r_state;
  bcast_state_t          w_state_nxt;

  logic [ADDR_W-1:0]     r_base;
  logic [31:0]           r_num_elems;
  logic [31:0]           r_num_vectors;
  logic [31:0]           r_beats;
  logic [31:0]           r_rd_cnt;
  logic [31:0]           r_rx_cnt;
  logic [31:0]           r_vec_cnt;

  logic                  r_bu_valid;
  logic [ADDR_W-1:0]     r_bu_addr;
  logic [8*LANES-1:0]    r_bu_data;
  logic                  r_err;

  logic                  w_cmd_bad;
  logic                  w_accept;
  logic                  w_rx_take;
  logic                  w_bcast_fire;

  assign w_cmd_bad    = (num_elems_i == 32'd0) || (num_elems_i > 32'(CACHE_DEPTH));
  assign w_accept     = (r_state == S_IDLE) && start_i && !w_cmd_bad;
  // Read returns only count while a load is in progress; anything else is stale.
  assign w_rx_take    = sram_rvalid_i && ((r_state == S_LOAD) || (r_state == S_DRAIN));
  assign w_bcast_fire = (r_state == S_BCAST) && out_ready_i;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    bu_init_o    = 1'b0;
    sram_rd_en_o = 1'b0;
    bu_en_o      = 1'b0;
    done_o       = 1'b0;
    busy_o       = (r_state != S_IDLE);

    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = S_INIT;
        end
      end
      S_INIT: begin
        bu_init_o   = 1'b1;
        w_state_nxt = S_LOAD;
      end
      S_LOAD: begin
        sram_rd_en_o = 1'b1;
        if (r_rd_cnt == r_beats - 32'd1) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // The final cache write is on the bus in the cycle rx_cnt reaches beats.
        if (r_rx_cnt == r_beats) begin
          w_state_nxt = (r_num_vectors == 32'd0) ? S_DONE : S_BCAST;
        end
      end
      S_BCAST: begin
        bu_en_o = out_ready_i;
        if (w_bcast_fire && (r_vec_cnt == r_num_vectors - 32'd1)) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        done_o      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_base        <= '0;
      r_num_elems   <= '0;
      r_num_vectors <= '0;
      r_beats       <= '0;
      r_rd_cnt      <= '0;
      r_rx_cnt      <= '0;
      r_vec_cnt     <= '0;
      r_bu_valid    <= 1'b0;
      r_bu_addr     <= '0;
      r_bu_data     <= '0;
      r_err         <= 1'b0;
    end else begin
      r_err      <= (r_state == S_IDLE) && start_i && w_cmd_bad;
      r_bu_valid <= w_rx_take;

      if (w_accept) begin
        r_base        <= src_base_i;
        r_num_elems   <= num_elems_i;
        r_num_vectors <= num_vectors_i;
      end

      if (r_state == S_INIT) begin
        r_beats   <= beats_for(r_num_elems, LANES);
        r_rd_cnt  <= '0;
        r_rx_cnt  <= '0;
        r_vec_cnt <= '0;
      end

      if (r_state == S_LOAD) begin
        r_rd_cnt <= r_rd_cnt + 32'd1;
      end

      if (w_rx_take) begin
        r_rx_cnt  <= r_rx_cnt + 32'd1;
        r_bu_addr <= ADDR_W'(r_rx_cnt * 32'(LANES));
        r_bu_data <= sram_rdata_i;
      end

      if (w_bcast_fire) begin
        r_vec_cnt <= r_vec_cnt + 32'd1;
      end
    end
  end

  assign sram_addr_o    = (r_state == S_LOAD) ? (r_base + ADDR_W'(r_rd_cnt)) : '0;
  assign bu_valid_o     = r_bu_valid;
  assign bu_addr_o      = r_bu_addr;
  assign bu_data_o      = r_bu_data;
  assign bu_num_elems_o = r_num_elems;
  assign err_o          = r_err;

endmodule
`default_nettype wire
